// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the MA-stage load/store interface.
// Accepts one word request per REQ/ACK handshake, holds it for LATENCY clock
// edges, then commits the store or returns load data with an error flag.
// Illegal addresses (misaligned, below BASE, or past the array) never touch
// the memory and always return Rdata=0 with ERR=1.
module dm_responder #(
  parameter int          ADDR_W  = 10,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] Adr,
  input  logic [31:0] WDATA,
  output logic [31:0] Rdata,
  output logic        ACK,
  output logic        ERR,
  output logic        BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Byte-span of the array, one bit wider than the address so ADDR_W=30 fits.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  // Parameter sanity, checked at elaboration.
  if (LATENCY < 1 || LATENCY > 255) begin : g_lat_chk
    $error("dm_responder: LATENCY=%0d outside 1..255", LATENCY);
  end
  if (ADDR_W < 1 || ADDR_W > 30) begin : g_aw_chk
    $error("dm_responder: ADDR_W=%0d outside 1..30", ADDR_W);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_accept;

  // Latched request; the live inputs are ignored after the accept edge.
  logic              r_we;
  logic [31:0]       r_adr;
  logic [31:0]       r_wdata;

  logic [31:0]       r_rdata;
  logic              r_ack;
  logic              r_err;

  logic [31:0]       r_mem [DEPTH];

  logic [31:0]       w_off;
  logic              w_bad;
  logic [ADDR_W-1:0] w_idx;
  logic              w_commit;

  // Address decode on the latched request. The offset compare is done at
  // 33 bits so the word-count limit never overflows.
  assign w_off    = r_adr - BASE;
  assign w_bad    = (r_adr[1:0] != 2'b00) || (r_adr < BASE) ||
                    ({1'b0, w_off} >= SPAN);
  assign w_idx    = w_off[ADDR_W+1:2];
  // The single edge on which a request takes effect (WAIT -> RESP).
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 8'd0);

  // State and wait-state counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 8'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Capture the request on the accept edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_we    <= 1'b0;
      r_adr   <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_we    <= WE;
      r_adr   <= Adr;
      r_wdata <= WDATA;
    end
  end

  // Registered response: ACK/ERR pulse for the RESP cycle, Rdata holds after.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else if (w_commit) begin
      r_ack   <= 1'b1;
      r_err   <= w_bad;
      r_rdata <= (r_we || w_bad) ? 32'h0 : r_mem[w_idx];
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  // Memory array, not reset. A reset before the commit edge forces IDLE,
  // so an interrupted store is never written.
  always_ff @(posedge CLK) begin
    if (w_commit && r_we && !w_bad) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign Rdata = r_rdata;
  assign ACK   = r_ack;
  assign ERR   = r_err;
  assign BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: u0 runs LATENCY=2, u1 runs LATENCY=1.
// Drivers push the expected response (data, error, ACK cycle) when they
// issue a request; a negedge monitor pops and compares on every ACK.
module tb_dm_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we  = '0;
  logic [1:0][31:0] adr = '0;
  logic [1:0][31:0] wd  = '0;

  logic [31:0] rd0, rd1;
  logic        ack0, ack1, err0, err1, busy0, busy1;

  always #5 CLK = ~CLK;

  dm_responder #(.ADDR_W(10), .LATENCY(2), .BASE(32'h0)) u0 (
    .CLK(CLK), .RST(RST), .REQ(req[0]), .WE(we[0]), .Adr(adr[0]),
    .WDATA(wd[0]), .Rdata(rd0), .ACK(ack0), .ERR(err0), .BUSY(busy0)
  );

  dm_responder #(.ADDR_W(10), .LATENCY(1), .BASE(32'h0)) u1 (
    .CLK(CLK), .RST(RST), .REQ(req[1]), .WE(we[1]), .Adr(adr[1]),
    .WDATA(wd[1]), .Rdata(rd1), .ACK(ack1), .ERR(err1), .BUSY(busy1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Rising-edge count; read only on falling edges.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(int u, logic a, logic e, logic [31:0] rd);
    exp_t x;
    if (a) begin
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL u%0d unexpected ack: got rdata=%h err=%b want no ack", u, rd, e);
      end else begin
        if (u == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        chk({x.name, " rdata"}, rd, x.rdata);
        chk({x.name, " err"}, 32'(e), 32'(x.err));
        chk({x.name, " ack cycle"}, 32'(cyc), 32'(x.cyc));
      end
    end else if (e) begin
      total++;
      bad++;
      $display("FAIL u%0d err without ack: got 1 want 0", u);
    end
  endtask

  // Monitor: compare every response against the scoreboard head.
  always @(negedge CLK) begin
    if (RST) begin
      mon(0, ack0, err0, rd0);
      mon(1, ack1, err1, rd1);
    end
  end

  // Issue a request (call just after a falling edge); expected ACK lands
  // LATENCY edges after the accept edge that follows.
  task automatic start(int u, logic w, logic [31:0] a, logic [31:0] d,
                       logic [31:0] erd, logic ee, string nm);
    exp_t x;
    x.rdata = erd;
    x.err   = ee;
    x.cyc   = cyc + 1 + ((u == 0) ? 2 : 1);
    x.name  = nm;
    if (u == 0) q0.push_back(x);
    else        q1.push_back(x);
    req[u] = 1'b1;
    we[u]  = w;
    adr[u] = a;
    wd[u]  = d;
  endtask

  // Hold the request until ACK, dropping REQ in the RESP cycle.
  task automatic wait_ack(int u);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((u == 0) ? ack0 : ack1) begin
        req[u] = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL u%0d ack timeout: got no ack in 20 cycles want ack", u);
    req[u] = 1'b0;
  endtask

  task automatic do_req(int u, logic w, logic [31:0] a, logic [31:0] d,
                        logic [31:0] erd, logic ee, string nm);
    @(negedge CLK);
    start(u, w, a, d, erd, ee, nm);
    wait_ack(u);
  endtask

  initial begin
    // Asynchronous reset, checked before the first clock edge.
    #2 RST = 1'b0;
    #1;
    chk("reset ack", 32'(ack0), 32'h0);
    chk("reset err", 32'(err0), 32'h0);
    chk("reset busy", 32'(busy0), 32'h0);
    chk("reset rdata", rd0, 32'h0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Basic store then load.
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, "st 0x10");
    do_req(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld 0x10");

    // Misaligned store aliases index 4 but must not be written.
    do_req(0, 1, 32'h13, 32'h12345678, 32'h0, 1, "st 0x13 misaligned");
    do_req(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld 0x10 after bad st");
    do_req(0, 0, 32'h11, 32'h0, 32'h0, 1, "ld 0x11 misaligned");

    // Range boundary: 0x1000 is one word past a 1024-word array.
    do_req(0, 1, 32'h0, 32'h11111111, 32'h0, 0, "st 0x0");
    do_req(0, 1, 32'h1000, 32'h22222222, 32'h0, 1, "st 0x1000 range");
    do_req(0, 0, 32'h1000, 32'h0, 32'h0, 1, "ld 0x1000 range");
    do_req(0, 0, 32'h0, 32'h0, 32'h11111111, 0, "ld 0x0 after bad st");
    do_req(0, 1, 32'hFFC, 32'h0BADF00D, 32'h0, 0, "st 0xFFC");
    do_req(0, 0, 32'hFFC, 32'h0, 32'h0BADF00D, 0, "ld 0xFFC");

    // Inputs scrambled during WAIT are ignored; BUSY high in WAIT and RESP.
    @(negedge CLK);
    start(0, 0, 32'hFFC, 32'h0, 32'h0BADF00D, 0, "ld 0xFFC scrambled");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("busy wait/resp", 32'(busy0), 32'h1);
      if (i == 0) begin
        req[0] = 1'b0; we[0] = 1'b1; adr[0] = 32'h10; wd[0] = 32'hFFFFFFFF;
      end else if (i == 1) begin
        req[0] = 1'b1; adr[0] = 32'h13;
      end else begin
        req[0] = 1'b0; we[0] = 1'b0;
      end
    end
    do_req(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "ld 0x10 after scramble");

    // Reset during WAIT of a store: Rdata drops, nothing is written.
    @(negedge CLK);
    start(0, 1, 32'h20, 32'hA5A5A5A5, 32'h0, 0, "st 0x20 aborted");
    @(posedge CLK);
    #2;
    chk("busy before reset", 32'(busy0), 32'h1);
    chk("rdata before reset", rd0, 32'hDEADBEEF);
    req[0] = 1'b0;
    RST = 1'b0;
    q0.delete();
    #1;
    chk("wait-reset busy", 32'(busy0), 32'h0);
    chk("wait-reset rdata", rd0, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // Reset during RESP of a bad load: ACK and ERR drop at once.
    start(0, 0, 32'h1000, 32'h0, 32'h0, 1, "ld aborted");
    repeat (3) @(posedge CLK);
    #1;
    chk("resp ack before reset", 32'(ack0), 32'h1);
    chk("resp err before reset", 32'(err0), 32'h1);
    req[0] = 1'b0;
    RST = 1'b0;
    q0.delete();
    #1;
    chk("resp-reset ack", 32'(ack0), 32'h0);
    chk("resp-reset err", 32'(err0), 32'h0);
    chk("resp-reset busy", 32'(busy0), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    do_req(0, 1, 32'h20, 32'h0, 32'h0, 0, "st 0x20 zero");
    do_req(0, 0, 32'h20, 32'h0, 32'h0, 0, "ld 0x20 zero");

    // LATENCY=1 instance: back-to-back requests, ACK one edge after accept.
    do_req(1, 1, 32'h10, 32'hCAFEF00D, 32'h0, 0, "u1 st 0x10");
    do_req(1, 1, 32'h14, 32'h01234567, 32'h0, 0, "u1 st 0x14");
    do_req(1, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0, "u1 ld 0x10");
    do_req(1, 0, 32'h14, 32'h0, 32'h01234567, 0, "u1 ld 0x14");
    do_req(1, 0, 32'h3FFC, 32'h0, 32'h0, 1, "u1 ld 0x3FFC range");
    do_req(1, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0, "u1 ld 0x10 again");

    repeat (4) @(negedge CLK);
    chk("u0 scoreboard drained", 32'(q0.size()), 32'h0);
    chk("u1 scoreboard drained", 32'(q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
